keypad_matrix_emulator: RTL



---
 rtl/keypad_matrix_emulator.sv | 94 +++++++++
 1 files changed

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: drives active-low column returns as a closed 4x4 keypad switch would,
// pressing one requested key with optional contact bounce, a hold time and a release gap.
module keypad_matrix_emulator #(
  parameter int HOLD_CYCLES   = 256,
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_TOGGLE = 2,
  parameter int GAP_CYCLES    = 32,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] scan_in,
  output logic [3:0] keyin_out,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(BOUNCE_TOGGLE - 1);
  localparam logic [CNT_W-1:0] LAST_H = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_G = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEN_G  = CNT_W'(GAP_CYCLES - 2);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tcnt;
  logic [3:0]       code;
  logic             contact;
  logic [1:0]       row_bit;
  logic             hit;
  // Row select is 3 - k[1:0], which for two bits is simply the complement.
  assign row_bit   = ~code[1:0];
  assign hit       = contact && !scan_in[row_bit];
  assign keyin_out = hit ? ~(4'b0001 << code[3:2]) : 4'b1111;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      code      <= '0;
      contact   <= 1'b0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (key_valid && key_ready) begin
            code      <= key_code;
            state     <= (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE_IN;
            contact   <= 1'b1;
            cnt       <= '0;
            tcnt      <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end else key_ready <= 1'b1;
        BOUNCE_IN, BOUNCE_OUT:
          if (cnt == LAST_B) begin
            state   <= (state == BOUNCE_IN) ? HOLD : GAP;
            contact <= (state == BOUNCE_IN);
            cnt     <= '0;
            tcnt    <= '0;
            done    <= (state == BOUNCE_OUT) && (GAP_CYCLES == 1);
          end else begin
            cnt  <= cnt + 1'b1;
            tcnt <= (tcnt == LAST_T) ? '0 : tcnt + 1'b1;
            if (tcnt == LAST_T) contact <= ~contact;
          end
        HOLD:
          if (cnt == LAST_H) begin
            state   <= (BOUNCE_CYCLES == 0) ? GAP : BOUNCE_OUT;
            contact <= 1'b0;
            cnt     <= '0;
            tcnt    <= '0;
            done    <= (BOUNCE_CYCLES == 0) && (GAP_CYCLES == 1);
          end else cnt <= cnt + 1'b1;
        GAP:
          if (cnt == LAST_G) begin
            state     <= IDLE;
            cnt       <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt  <= cnt + 1'b1;
            done <= (cnt == PEN_G);
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
